rcb_frl_msg_rx_align: RTL
=========================

// Module: rcb_frl_msg_rx_align
// PURPOSE
//  Receive-side counterpart of the FRL message serializer: takes 8-bit words from the 1:8 ISERDES
//  (one word per CLK, DI[7] = first bit on the wire), word-aligns via BITSLIP training and extracts
//  fixed-length messages. Sits between the message-link ISERDES and the radio control message sink.
// PARAMETERS
//  TRAIN_PATTERN  8'h5C  idle/training byte sent by the transmitter between messages
//  HEADER         8'hF5  start-of-message byte
//  MSG_LEN        8      payload bytes per message (1..255)
//  LOCK_COUNT     16     consecutive TRAIN_PATTERN words required to declare lock (1..255)
//  SLIP_WAIT      3      CLK cycles ignored after each BITSLIP pulse (ISERDES settling) (1..15)
//  MAX_SLIPS      8      slips without lock before ALIGN_ERR is pulsed
//  LOSS_COUNT     4      consecutive invalid idle words that drop lock (1..15)
// PORTS
//  CLK          in   1  divided (word) clock, same as ISERDES CLKDIV
//  RST          in   1  asynchronous, active-high reset
//  DI           in   8  deserialized word, DI[7] earliest bit
//  BITSLIP      out  1  one-cycle pulse to ISERDES BITSLIP
//  LOCKED       out  1  word alignment achieved
//  MSG_DATA     out  8  payload byte
//  MSG_VALID    out  1  MSG_DATA valid this cycle
//  MSG_SOF      out  1  first payload byte (with MSG_VALID)
//  MSG_EOF      out  1  last payload byte (with MSG_VALID)
//  MSG_CRC_OK   out  1  one-cycle pulse: checksum matched
//  MSG_CRC_ERR  out  1  one-cycle pulse: checksum mismatch
//  ALIGN_ERR    out  1  one-cycle pulse: MAX_SLIPS slips without lock
// BEHAVIOUR
//  - All outputs registered; reset value of every output 0. Reset enters HUNT, clears all counters.
//  - Latency: a byte on DI at edge t produces its outputs visible after edge t (1 cycle).
//  - States: HUNT, SLIP_WAIT, IDLE, PAYLOAD, CHECK.
//  - HUNT: DI==TRAIN_PATTERN -> match_cnt++; match_cnt reaching LOCK_COUNT -> LOCKED=1, IDLE.
//    DI!=TRAIN_PATTERN -> match_cnt=0, BITSLIP=1 for one cycle, slip_cnt++, go SLIP_WAIT.
//    slip_cnt reaching MAX_SLIPS -> ALIGN_ERR pulse same cycle as that BITSLIP, slip_cnt=0, keep hunting.
//    HEADER bytes in HUNT are treated as mismatches.
//  - SLIP_WAIT: ignore DI for SLIP_WAIT cycles, then HUNT. No BITSLIP while waiting.
//  - IDLE (locked): DI==TRAIN_PATTERN -> bad_cnt=0. DI==HEADER -> bad_cnt=0, sum=0, byte_cnt=0,
//    go PAYLOAD. Other -> bad_cnt++; reaching LOSS_COUNT -> LOCKED=0, match_cnt=slip_cnt=0, HUNT.
//  - PAYLOAD: every DI is data (HEADER/TRAIN values included): MSG_VALID=1, MSG_DATA=DI,
//    MSG_SOF on byte_cnt==0, MSG_EOF on byte_cnt==MSG_LEN-1 (MSG_LEN=1 -> SOF and EOF together);
//    sum = (sum+DI) mod 256. After last byte -> CHECK. No lock-loss checking in PAYLOAD/CHECK.
//  - CHECK: DI is checksum byte; DI==sum -> MSG_CRC_OK pulse else MSG_CRC_ERR; -> IDLE.
//    Back-to-back messages allowed: HEADER may arrive the cycle after the checksum.
//  - Exactly one of MSG_CRC_OK/MSG_CRC_ERR per completed message; never both.
//  - Reset mid-message: outputs drop to 0 asynchronously; no EOF/CRC pulse is emitted for the
//    truncated message; relock required.
//  - LOCKED stays 1 through PAYLOAD/CHECK; drops only from IDLE loss detection or RST.
// TESTING
//  1. DI constant 8'h5C from reset -> no BITSLIP, LOCKED=1 after 16th word, visible cycle 17.
//  2. Stream rotated by 3 bits (8'h8B) -> BITSLIP pulses spaced 4 cycles; after model slips 3
//     times (words become 8'h5C) LOCKED after 16 matches; ALIGN_ERR never.
//  3. Locked; send F5,01..08,24 -> 8 MSG_VALID bytes 01..08, SOF on 01, EOF on 08, MSG_CRC_OK
//     the cycle after; same with checksum 25 -> MSG_CRC_ERR only.
//  4. Locked; payload containing F5 and 5C, back-to-back messages -> all treated as data, two CRC_OK.
//  5. Locked; 3 bad idle words then 5C -> stays locked; 4 bad words -> LOCKED=0, HUNT, BITSLIP resumes.
//  6. Never-matching DI (8'h00) -> ALIGN_ERR every 8th BITSLIP; RST asserted mid-PAYLOAD -> all
//     outputs 0 immediately, no EOF/CRC pulse after release.

Source files
------------

// File: rtl/rcb_frl_msg_rx_align.sv
// Receive-side word aligner and message extractor for the FRL message link.
// Trains ISERDES word alignment with BITSLIP, then frames HEADER + payload + checksum messages.
module rcb_frl_msg_rx_align #(
    parameter logic [7:0] TRAIN_PATTERN = 8'h5C,
    parameter logic [7:0] HEADER        = 8'hF5,
    parameter int         MSG_LEN       = 8,
    parameter int         LOCK_COUNT    = 16,
    parameter int         SLIP_WAIT     = 3,
    parameter int         MAX_SLIPS     = 8,
    parameter int         LOSS_COUNT    = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [7:0] DI,
    output logic       BITSLIP,
    output logic       LOCKED,
    output logic [7:0] MSG_DATA,
    output logic       MSG_VALID,
    output logic       MSG_SOF,
    output logic       MSG_EOF,
    output logic       MSG_CRC_OK,
    output logic       MSG_CRC_ERR,
    output logic       ALIGN_ERR,
    output logic [2:0] DBG_STATE
);

    localparam logic [7:0] LEN_LAST  = 8'(MSG_LEN - 1);
    localparam logic [7:0] LOCK_LAST = 8'(LOCK_COUNT - 1);
    localparam logic [7:0] SLIP_LAST = 8'(MAX_SLIPS - 1);
    localparam logic [3:0] WAIT_LAST = 4'(SLIP_WAIT - 1);
    localparam logic [3:0] LOSS_LAST = 4'(LOSS_COUNT - 1);

    typedef enum logic [2:0] {
        ST_HUNT      = 3'd0,
        ST_SLIP_WAIT = 3'd1,
        ST_IDLE      = 3'd2,
        ST_PAYLOAD   = 3'd3,
        ST_CHECK     = 3'd4
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] match_cnt_q, match_cnt_d;
    logic [7:0] slip_cnt_q, slip_cnt_d;
    logic [3:0] wait_cnt_q, wait_cnt_d;
    logic [3:0] bad_cnt_q, bad_cnt_d;
    logic [7:0] byte_cnt_q, byte_cnt_d;
    logic [7:0] sum_q, sum_d;
    logic       bitslip_q, bitslip_d;
    logic       locked_q, locked_d;
    logic [7:0] msg_data_q, msg_data_d;
    logic       msg_valid_q, msg_valid_d;
    logic       msg_sof_q, msg_sof_d;
    logic       msg_eof_q, msg_eof_d;
    logic       crc_ok_q, crc_ok_d;
    logic       crc_err_q, crc_err_d;
    logic       align_err_q, align_err_d;

    // Message stream is valid-only: the sink must accept a byte on every cycle MSG_VALID is high.
    always_comb begin
        state_d     = state_q;
        match_cnt_d = match_cnt_q;
        slip_cnt_d  = slip_cnt_q;
        wait_cnt_d  = wait_cnt_q;
        bad_cnt_d   = bad_cnt_q;
        byte_cnt_d  = byte_cnt_q;
        sum_d       = sum_q;
        locked_d    = locked_q;
        bitslip_d   = 1'b0;
        msg_data_d  = 8'h00;
        msg_valid_d = 1'b0;
        msg_sof_d   = 1'b0;
        msg_eof_d   = 1'b0;
        crc_ok_d    = 1'b0;
        crc_err_d   = 1'b0;
        align_err_d = 1'b0;

        case (state_q)
            ST_HUNT: begin
                if (DI == TRAIN_PATTERN) begin
                    if (match_cnt_q == LOCK_LAST) begin
                        locked_d    = 1'b1;
                        match_cnt_d = 8'd0;
                        bad_cnt_d   = 4'd0;
                        state_d     = ST_IDLE;
                    end else begin
                        match_cnt_d = match_cnt_q + 8'd1;
                    end
                end else begin
                    match_cnt_d = 8'd0;
                    bitslip_d   = 1'b1;
                    wait_cnt_d  = 4'd0;
                    state_d     = ST_SLIP_WAIT;
                    if (slip_cnt_q == SLIP_LAST) begin
                        align_err_d = 1'b1;
                        slip_cnt_d  = 8'd0;
                    end else begin
                        slip_cnt_d = slip_cnt_q + 8'd1;
                    end
                end
            end
            ST_SLIP_WAIT: begin
                if (wait_cnt_q == WAIT_LAST) state_d = ST_HUNT;
                else wait_cnt_d = wait_cnt_q + 4'd1;
            end
            ST_IDLE: begin
                if (DI == TRAIN_PATTERN) begin
                    bad_cnt_d = 4'd0;
                end else if (DI == HEADER) begin
                    bad_cnt_d  = 4'd0;
                    sum_d      = 8'h00;
                    byte_cnt_d = 8'd0;
                    state_d    = ST_PAYLOAD;
                end else if (bad_cnt_q == LOSS_LAST) begin
                    locked_d    = 1'b0;
                    match_cnt_d = 8'd0;
                    slip_cnt_d  = 8'd0;
                    bad_cnt_d   = 4'd0;
                    state_d     = ST_HUNT;
                end else begin
                    bad_cnt_d = bad_cnt_q + 4'd1;
                end
            end
            ST_PAYLOAD: begin
                msg_valid_d = 1'b1;
                msg_data_d  = DI;
                msg_sof_d   = (byte_cnt_q == 8'd0);
                msg_eof_d   = (byte_cnt_q == LEN_LAST);
                sum_d       = sum_q + DI;
                if (byte_cnt_q == LEN_LAST) state_d = ST_CHECK;
                else byte_cnt_d = byte_cnt_q + 8'd1;
            end
            ST_CHECK: begin
                crc_ok_d  = (DI == sum_q);
                crc_err_d = (DI != sum_q);
                state_d   = ST_IDLE;
            end
            default: state_d = ST_HUNT;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= ST_HUNT;
            match_cnt_q <= 8'd0;
            slip_cnt_q  <= 8'd0;
            wait_cnt_q  <= 4'd0;
            bad_cnt_q   <= 4'd0;
            byte_cnt_q  <= 8'd0;
            sum_q       <= 8'h00;
            bitslip_q   <= 1'b0;
            locked_q    <= 1'b0;
            msg_data_q  <= 8'h00;
            msg_valid_q <= 1'b0;
            msg_sof_q   <= 1'b0;
            msg_eof_q   <= 1'b0;
            crc_ok_q    <= 1'b0;
            crc_err_q   <= 1'b0;
            align_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            match_cnt_q <= match_cnt_d;
            slip_cnt_q  <= slip_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            bad_cnt_q   <= bad_cnt_d;
            byte_cnt_q  <= byte_cnt_d;
            sum_q       <= sum_d;
            bitslip_q   <= bitslip_d;
            locked_q    <= locked_d;
            msg_data_q  <= msg_data_d;
            msg_valid_q <= msg_valid_d;
            msg_sof_q   <= msg_sof_d;
            msg_eof_q   <= msg_eof_d;
            crc_ok_q    <= crc_ok_d;
            crc_err_q   <= crc_err_d;
            align_err_q <= align_err_d;
        end
    end

    assign BITSLIP     = bitslip_q;
    assign LOCKED      = locked_q;
    assign MSG_DATA    = msg_data_q;
    assign MSG_VALID   = msg_valid_q;
    assign MSG_SOF     = msg_sof_q;
    assign MSG_EOF     = msg_eof_q;
    assign MSG_CRC_OK  = crc_ok_q;
    assign MSG_CRC_ERR = crc_err_q;
    assign ALIGN_ERR   = align_err_q;
    assign DBG_STATE   = state_q;

endmodule
